// File: rtl/registro_d_4bits_oe_if.sv
// Bus-side signal bundle for registro_d_4bits_oe: load/output enables, data in and
// the shared tri-state data bus Q.
interface registro_d_4bits_oe_if #(parameter int WIDTH = 4);
    logic             EN;
    logic             OE;
    logic [WIDTH-1:0] D;
    wire  [WIDTH-1:0] Q;

    modport master (output EN, output OE, output D, input Q);
    modport slave  (input EN, input OE, input D, output Q);
endinterface

// File: rtl/registro_d_4bits_oe.sv
// D register with synchronous load enable and tri-state output onto a shared bus.
// Optional macro REGD_OE_QINT_EN adds Q_INT, an always-driven readback of the stored value.
module registro_d_4bits_oe #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    registro_d_4bits_oe_if.slave bus
`ifdef REGD_OE_QINT_EN
    ,
    output logic [WIDTH-1:0]  Q_INT
`endif
);

    logic [WIDTH-1:0] data_r;

    always_ff @(posedge clk) begin
        if (rst)
            data_r <= '0;
        else if (bus.EN)
            data_r <= bus.D;
    end

    // OE gates only the bus driver; storage keeps updating while the bus is released
    assign bus.Q = bus.OE ? data_r : {WIDTH{1'bz}};

`ifdef REGD_OE_QINT_EN
    assign Q_INT = data_r;
`endif

endmodule

// File: tb/tb_registro_d_4bits_oe.sv
// Randomized self-checking bench for registro_d_4bits_oe against a behavioural model.
// A released bus is checked by parking a known value on Q from the bench side.
module tb_registro_d_4bits_oe;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic             park;
    logic [WIDTH-1:0] park_val;
    logic [WIDTH-1:0] model;

    registro_d_4bits_oe_if #(.WIDTH(WIDTH)) bus ();

`ifdef REGD_OE_QINT_EN
    logic [WIDTH-1:0] q_int;
`endif

    registro_d_4bits_oe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef REGD_OE_QINT_EN
        ,
        .Q_INT (q_int)
`endif
    );

    // second bus agent: only drives while the DUT is expected to be off the bus
    assign bus.Q = park ? park_val : {WIDTH{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Q when OE=1 must equal the stored value; when OE=0 the bus must carry only the parked value
    task automatic chk_q(input string tag);
        if (bus.OE) begin
            chk(tag, bus.Q, model);
        end else begin
            park_val = WIDTH'($urandom);
            park = 1'b1;
            #1;
            chk({tag, "_z"}, bus.Q, park_val);
            park = 1'b0;
        end
`ifdef REGD_OE_QINT_EN
        chk({tag, "_qint"}, q_int, model);
`endif
    endtask

    // one clock: drive at negedge, update model with the rules at posedge, check after it
    task automatic step(input logic r, input logic en, input logic oe, input logic [WIDTH-1:0] d,
                        input string tag);
        @(negedge clk);
        rst    = r;
        bus.EN = en;
        bus.OE = oe;
        bus.D  = d;
        @(posedge clk);
        if (r)
            model = '0;
        else if (en)
            model = d;
        #1;
        chk_q(tag);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        park     = 1'b0;
        park_val = '0;
        model    = '0;
        rst      = 1'b0;
        bus.EN   = 1'b0;
        bus.OE   = 1'b0;
        bus.D    = '0;

        // T1 reset, then release the bus
        step(1'b1, 1'b0, 1'b1, 4'b0000, "t1_reset");
        @(negedge clk);
        rst    = 1'b0;
        bus.OE = 1'b0;
        #1;
        chk_q("t1_oe_off");

        // T2 visible load, T3 hold
        step(1'b0, 1'b1, 1'b1, 4'b1010, "t2_load");
        chk(" t2_exact", bus.Q, 4'b1010);
        step(1'b0, 1'b0, 1'b1, 4'b0101, "t3_hold");
        chk(" t3_exact", bus.Q, 4'b1010);

        // T4 hidden load, T5 reveal without a clock edge
        step(1'b0, 1'b1, 1'b0, 4'b1111, "t4_hidden");
        @(negedge clk);
        bus.EN = 1'b0;
        #2;
        bus.OE = 1'b1;
        #1;
        chk("t5_reveal", bus.Q, 4'b1111);
        bus.OE = 1'b0;
        #1;
        chk_q("t5_off");

        // T6 reset raised mid-cycle has no effect until the edge, and beats EN
        step(1'b0, 1'b1, 1'b1, 4'b0011, "t6_preload");
        @(negedge clk);
        bus.OE = 1'b1;
        #1;
        rst    = 1'b1;
        bus.EN = 1'b1;
        bus.D  = 4'b0110;
        #2;
        chk("t6_midcycle", bus.Q, 4'b0011);
        @(posedge clk);
        model = '0;
        #1;
        chk("t6_prio", bus.Q, 4'b0000);
        chk_q("t6_after");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), WIDTH'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
